// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch block: FSM states, widths and
// instruction field helpers.
package instr_fetch_pkg;

    localparam int          INSTR_LEN    = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          JTARGET_MSB  = 25;
    localparam int          JTARGET_LSB  = 0;
    localparam int          OPCODE_MSB   = 31;
    localparam int          OPCODE_LSB   = 26;

    typedef enum logic {
        IF_FETCH = 1'b0,
        IF_EXEC  = 1'b1
    } if_state_e;

    function automatic logic [JTARGET_MSB-JTARGET_LSB:0] jtarget(input logic [INSTR_LEN-1:0] word);
        return word[JTARGET_MSB:JTARGET_LSB];
    endfunction

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode(input logic [INSTR_LEN-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Combinational next-PC selection; kept standalone so a pipelined fetch can reuse it.
module next_pc_logic
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = INSTR_LEN
) (
    input  logic [ADDR_W-1:0]  pc_plus4,
    input  logic [INSTR_W-1:0] instr,
    input  logic [31:0]        imm_ext,
    input  logic               branch,
    input  logic               jump,
    input  logic               alu_zero,
    output logic [ADDR_W-1:0]  next_pc
);

    // Jump outranks a taken branch; the jump keeps the top nibble of pc+4.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = ADDR_W'({pc_plus4[ADDR_W-1 -: 4], jtarget(INSTR_LEN'(instr)), 2'b00});
        end else if (branch && alu_zero) begin
            next_pc = pc_plus4 + ADDR_W'(imm_ext << 2);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, fetches through a req/ready handshake, holds the
// word for execute and counts retired instructions.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ADDR_W   = 32,
    parameter int          INSTR_W  = INSTR_LEN
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    input  logic               stall,
    input  logic               branch,
    input  logic               jump,
    input  logic               alu_zero,
    input  logic [31:0]        imm_ext,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus4,
    output logic [31:0]        retired
);

    if_state_e         state;
    if_state_e         state_next;
    logic [ADDR_W-1:0] next_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IF_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IF_FETCH: if (imem_ready) state_next = IF_EXEC;
            IF_EXEC:  if (!stall)     state_next = IF_FETCH;
            default:                  state_next = IF_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= ADDR_W'(RESET_PC);
            instr   <= '0;
            retired <= '0;
        end else if (state == IF_FETCH) begin
            if (imem_ready) instr <= imem_rdata;
        end else if (!stall) begin
            pc      <= next_pc;
            retired <= retired + 32'd1;
        end
    end

    // Request is gated by rst_n so it drops the instant reset is asserted.
    assign imem_req    = (state == IF_FETCH) && rst_n;
    assign imem_addr   = pc;
    assign instr_valid = (state == IF_EXEC);
    assign pc_plus4    = pc + ADDR_W'(4);

    next_pc_logic #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_next_pc (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .imm_ext  (imm_ext),
        .branch   (branch),
        .jump     (jump),
        .alu_zero (alu_zero),
        .next_pc  (next_pc)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized programs
// compared against a behavioural model of fetch/execute/retire.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] ADDI     = 32'h2008_0005;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        branch;
    logic        jump;
    logic        alu_zero;
    logic [31:0] imm_ext;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_retired;
    bit          m_exec;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .stall       (stall),
        .branch      (branch),
        .jump        (jump),
        .alu_zero    (alu_zero),
        .imm_ext     (imm_ext),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .retired     (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] target(input logic [31:0] cur, input logic [31:0] word,
                                           input logic br, input logic j, input logic z,
                                           input logic [31:0] imm);
        logic [31:0] seq;
        seq = cur + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
        if (br && z) return seq + imm * 32'd4;
        return seq;
    endfunction

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_instr   = 32'h0;
        m_retired = 32'h0;
        m_exec    = 1'b0;
    endtask

    // One clock: advance the model from the inputs seen at the edge, then sample.
    task automatic tick();
        if (!m_exec) begin
            if (imem_ready) begin
                m_instr = imem_rdata;
                m_exec  = 1'b1;
            end
        end else if (!stall) begin
            m_pc      = target(m_pc, m_instr, branch, jump, alu_zero, imm_ext);
            m_retired = m_retired + 32'd1;
            m_exec    = 1'b0;
        end
        @(posedge clk);
        #1;
        checks++;
        if (pc[1:0] !== 2'b00) begin
            errors++;
            $display("[TB] FAIL pc_align: pc=%h low bits not 00", pc);
        end
    endtask

    task automatic clear_inputs();
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        stall      = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_zero   = 1'b0;
        imm_ext    = 32'h0;
    endtask

    // Fetch one word after some wait cycles, stall it, then retire it with the given controls.
    task automatic run_instr(input logic [31:0] word, input int waits, input logic br,
                             input logic j, input logic z, input logic [31:0] imm,
                             input int stalls);
        clear_inputs();
        imem_rdata = $urandom;
        repeat (waits) tick();
        imem_rdata = word;
        imem_ready = 1'b1;
        tick();
        stall = 1'b1;
        repeat (stalls) begin
            imem_ready = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            branch     = 1'($urandom_range(0, 1));
            jump       = 1'($urandom_range(0, 1));
            alu_zero   = 1'($urandom_range(0, 1));
            imm_ext    = $urandom;
            tick();
        end
        stall      = 1'b0;
        imem_ready = 1'($urandom_range(0, 1));
        branch     = br;
        jump       = j;
        alu_zero   = z;
        imm_ext    = imm;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (pc !== RESET_PC) begin errors++; $display("[TB] FAIL reset_pc: got %h want %h", pc, RESET_PC); end
        checks++; if (instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h want 0", instr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (retired !== 32'h0) begin errors++; $display("[TB] FAIL reset_retired: got %h want 0", retired); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b want 0", imem_req); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        imem_rdata = ADDI;
        imem_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL seq_req0: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL seq_addr0: got %h want 0", imem_addr); end
        tick();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid1: got %b want 1", instr_valid); end
        checks++; if (instr !== ADDI) begin errors++; $display("[TB] FAIL seq_instr: got %h want %h", instr, ADDI); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL seq_req_exec: got %b want 0", imem_req); end
        tick();
        checks++; if (pc !== 32'h4) begin errors++; $display("[TB] FAIL seq_pc4: got %h want 4", pc); end
        checks++; if (retired !== 32'd1) begin errors++; $display("[TB] FAIL seq_retired1: got %0d want 1", retired); end
        checks++; if (pc_plus4 !== 32'h8) begin errors++; $display("[TB] FAIL seq_pc_plus4: got %h want 8", pc_plus4); end
        run_instr(ADDI, 0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        checks++; if (pc !== 32'h8) begin errors++; $display("[TB] FAIL seq_pc8: got %h want 8", pc); end
    endtask

    task automatic test_wait_states();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (imem_req !== 1'b1 || instr_valid !== 1'b0 || pc !== 32'h8) begin
                errors++;
                $display("[TB] FAIL wait_hold: req=%b valid=%b pc=%h want 1 0 00000008", imem_req, instr_valid, pc);
            end
        end
        imem_rdata = ADDI;
        imem_ready = 1'b1;
        tick();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL wait_done: got %b want 1", instr_valid); end
        clear_inputs();
        tick();
        checks++; if (pc !== 32'hC || retired !== 32'd3) begin errors++; $display("[TB] FAIL wait_retire: pc=%h retired=%0d want 0000000c 3", pc, retired); end
    endtask

    task automatic test_branch();
        run_instr(ADDI, 1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        checks++; if (pc !== 32'h10) begin errors++; $display("[TB] FAIL br_setup: got %h want 10", pc); end
        run_instr(32'h1000_FFFF, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1);
        checks++; if (pc !== 32'h4) begin errors++; $display("[TB] FAIL br_taken: got %h want 4", pc); end
        repeat (3) run_instr(ADDI, 0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        run_instr(32'h1000_FFFF, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 0);
        checks++; if (pc !== 32'h14) begin errors++; $display("[TB] FAIL br_not_taken: got %h want 14", pc); end
    endtask

    task automatic test_jump();
        run_instr(ADDI, 0, 1'b1, 1'b0, 1'b1, 32'h07FF_FFFA, 0);
        checks++; if (pc !== 32'h2000_0000) begin errors++; $display("[TB] FAIL jmp_setup: got %h want 20000000", pc); end
        run_instr(32'h0800_0040, 0, 1'b0, 1'b1, 1'b0, 32'h0, 0);
        checks++; if (pc !== 32'h2000_0100) begin errors++; $display("[TB] FAIL jmp_target: got %h want 20000100", pc); end
        run_instr(ADDI, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFBF, 0);
        run_instr(32'h0800_0040, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 0);
        checks++; if (pc !== 32'h2000_0100) begin errors++; $display("[TB] FAIL jmp_priority: got %h want 20000100", pc); end
    endtask

    task automatic test_stall();
        logic [31:0] pc0;
        logic [31:0] r0;
        logic [31:0] w;
        w   = 32'h0123_4567;
        pc0 = pc;
        r0  = retired;
        clear_inputs();
        imem_rdata = w;
        imem_ready = 1'b1;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            imem_rdata = $urandom;
            tick();
            checks++;
            if (instr !== w || pc !== pc0 || retired !== r0 || instr_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_hold: instr=%h pc=%h retired=%0d valid=%b want %h %h %0d 1", instr, pc, retired, instr_valid, w, pc0, r0);
            end
        end
        stall      = 1'b0;
        imem_ready = 1'b0;
        tick();
        checks++; if (pc !== pc0 + 32'd4 || retired !== r0 + 32'd1) begin errors++; $display("[TB] FAIL stall_release: pc=%h retired=%0d want %h %0d", pc, retired, pc0 + 32'd4, r0 + 32'd1); end
        tick();
        checks++; if (pc !== pc0 + 32'd4) begin errors++; $display("[TB] FAIL stall_once: got %h want %h", pc, pc0 + 32'd4); end
    endtask

    task automatic test_wrap();
        logic [31:0] imm;
        imm = (32'hFFFF_FFFC - (m_pc + 32'd4)) >> 2;
        run_instr(ADDI, 0, 1'b1, 1'b0, 1'b1, imm, 0);
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_setup: got %h want fffffffc", pc); end
        run_instr(ADDI, 0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc: got %h want 0", pc); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_instr($urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2));
            checks++;
            if (pc !== m_pc || retired !== m_retired || instr !== m_instr) begin
                errors++;
                $display("[TB] FAIL random_%0d: pc=%h retired=%0d instr=%h want %h %0d %h", i, pc, retired, instr, m_pc, m_retired, m_instr);
            end
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        imem_rdata = 32'hDEAD_BEEC;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        stall      = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (pc !== RESET_PC || instr !== 32'h0 || instr_valid !== 1'b0 || retired !== 32'h0 || imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: pc=%h instr=%h valid=%b retired=%0d req=%b", pc, instr, instr_valid, retired, imem_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin errors++; $display("[TB] FAIL async_restart: req=%b addr=%h want 1 %h", imem_req, imem_addr, RESET_PC); end
        run_instr(ADDI, 1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        checks++; if (pc !== RESET_PC + 32'd4 || retired !== 32'd1) begin errors++; $display("[TB] FAIL async_first: pc=%h retired=%0d want %h 1", pc, retired, RESET_PC + 32'd4); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_states();
        test_branch();
        test_jump();
        test_stall();
        test_wrap();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Upstream neighbour of control_unit in the CPU. Owns the PC, fetches the instruction word from instruction memory through a req/ready handshake, and holds it stable for decode and execute.
- Computes the next PC from the branch, jump and ALU-zero results of the executing instruction, then starts the next fetch.
- Keeps a retired-instruction counter for performance checks.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- ADDR_W, 32, width of the PC and instruction address.
- INSTR_W, `INSTR_LEN (32), width of the instruction word.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch address; always equals pc.
- imem_rdata  in  INSTR_W  instruction word; valid in the same cycle as imem_ready.
- imem_ready  in  1  memory has data this cycle; only honoured while imem_req=1.
- stall  in  1  downstream hold; keeps the current instruction in execute.
- branch  in  1  from control_unit.
- jump  in  1  from control_unit.
- alu_zero  in  1  ALU zero flag of the executing instruction.
- imm_ext  in  32  extended immediate from the extender; control_unit's sign_ext already applied.
- instr  out  INSTR_W  held instruction, feeds control_unit.
- instr_valid  out  1  instr is valid and executing this cycle.
- pc  out  ADDR_W  address of the held or fetching instruction.
- pc_plus4  out  ADDR_W  pc + 4.
- retired  out  32  count of completed instructions.

Behaviour:
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, retired=0.
  - imem_req=0 while rst_n=0.
- FETCH state:
  - imem_req=1 and imem_addr=pc.
  - If imem_ready=0: stay in FETCH, no state change.
  - If imem_ready=1: at the clock edge, instr<=imem_rdata, instr_valid<=1, state<=EXEC.
- EXEC state:
  - imem_req=0 and instr_valid=1.
  - If stall=1: instr, pc and retired are all held.
  - If stall=0: at the clock edge, pc<=next_pc, instr_valid<=0, retired<=retired+1, state<=FETCH.
- next_pc is combinational, with jump having priority over branch:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else branch=1 and alu_zero=1: pc_plus4 + (imm_ext<<2), truncated to 32 bits.
  - else: pc_plus4.
- Latency: with zero-wait memory, each instruction takes 2 cycles (FETCH then EXEC). Each wait cycle on imem_ready adds one cycle.
- Arithmetic: all additions are modulo 2^32. pc 32'hFFFF_FFFC retiring sequentially gives pc=0. retired wraps from 32'hFFFF_FFFF to 0.
- branch/jump/alu_zero are ignored in FETCH, and whenever stall=1.
- imem_ready=1 in EXEC is ignored; no fetch is outstanding.
- Reset mid-fetch abandons the request. The memory must tolerate req dropping without ready.
- Reset mid-stall discards the held instruction; it does not retire.
- pc[1:0] stays 2'b00 at all times because RESET_PC is aligned and all targets are multiples of 4. The bench asserts this.

Decomposition:
- Shared include defines.v gains:
  - `RESET_PC
  - state encodings `IF_FETCH=1'b0 and `IF_EXEC=1'b1
  - instruction field macro `JTARGET for bits 25:0
- Existing `INSTR_LEN and `OPCODE are reused.
- One combinational sub-module, next_pc_logic: inputs pc_plus4, instr, imm_ext, branch, jump, alu_zero; output next_pc. It is reusable by a later pipelined design.

Test Plan:
- Reset then zero-wait memory returning 32'h2008_0005 (addi): imem_addr=0 in cycle 0; instr_valid=1 in cycle 1. Sequential program: pc goes 0, 4, 8, with retired=1 at pc=4.
- imem_ready held low 3 cycles at pc=8: imem_req stays 1, instr_valid stays 0, pc=8 throughout. Fetch completes on cycle 4.
- beq at pc=0x10, imm_ext=32'hFFFF_FFFC, alu_zero=1: next pc = 0x14 - 16 = 0x4. Same with alu_zero=0: next pc = 0x14.
- j with instr[25:0]=26'h000_0040 at pc=0x2000_0000: next pc = 0x2000_0100. With branch=1 and alu_zero=1 also asserted, jump still wins.
- stall=1 for 2 cycles in EXEC: instr, pc and retired are unchanged. On release the PC advances exactly once.
- Async reset pulse mid-EXEC with stall=1: outputs return to reset values immediately, without a clock edge. After release, fetch restarts at RESET_PC and retired=0.
